// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Memory read port and control-unit handshake of the fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
  parameter int ADDR_W = 8
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic [15:0]       inst;
  logic              inst_valid;
  logic              done;

  modport master (
    output mem_rd, mem_addr, inst, inst_valid,
    input  mem_data, done
  );

  modport slave (
    input  mem_rd, mem_addr, inst, inst_valid,
    output mem_data, done
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Sequential instruction fetcher: fetch, wait, issue until done.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int          ADDR_W    = 8,
  parameter logic [15:0] HALT_INST = 16'hFFFF
) (
  input  wire               clk,
  input  wire               reset,
  input  wire               start,
  input  wire               halt_req,
  fetch_unit_if.master      bus,
  output logic [ADDR_W-1:0] pc,
  output logic              running,
  output logic              halted,
  output logic [15:0]       inst_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_ISSUE  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] c_pc_one  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [15:0]       c_cnt_max = 16'hFFFF;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_inst;
  logic [15:0]       r_count;
  logic              r_inst_valid;
  logic              r_mem_rd;
  logic              r_running;
  logic              r_halted;
  logic              r_halt_pend;
  logic              w_stop;

  // A halt request arriving in the same cycle as done still takes effect.
  assign w_stop = r_halt_pend | halt_req;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_HALTED: if (start) w_next = S_FETCH;
      S_FETCH:          w_next = S_WAIT;
      S_WAIT:           w_next = (bus.mem_data == HALT_INST) ? S_HALTED : S_ISSUE;
      S_ISSUE:          if (bus.done) w_next = w_stop ? S_HALTED : S_FETCH;
      default:          w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_inst       <= '0;
      r_count      <= '0;
      r_inst_valid <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_running    <= 1'b0;
      r_halted     <= 1'b0;
      r_halt_pend  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_mem_rd     <= (w_next == S_FETCH);
      r_inst_valid <= (w_next == S_ISSUE);
      r_running    <= (w_next == S_FETCH) || (w_next == S_WAIT) || (w_next == S_ISSUE);
      r_halted     <= (w_next == S_HALTED);

      case (r_state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            r_pc        <= '0;
            r_count     <= '0;
            r_halt_pend <= 1'b0;
          end
        end
        S_FETCH: begin
          if (halt_req) r_halt_pend <= 1'b1;
        end
        S_WAIT: begin
          if (halt_req) r_halt_pend <= 1'b1;
          r_inst <= bus.mem_data;
        end
        S_ISSUE: begin
          if (halt_req) r_halt_pend <= 1'b1;
          if (bus.done) begin
            r_pc <= r_pc + c_pc_one;
            if (r_count != c_cnt_max) r_count <= r_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_rd     = r_mem_rd;
  assign bus.mem_addr   = r_pc;
  assign bus.inst       = r_inst;
  assign bus.inst_valid = r_inst_valid;
  assign pc             = r_pc;
  assign running        = r_running;
  assign halted         = r_halted;
  assign inst_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit (tables, corners, random).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [15:0] C_HALT = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, halt_req;
  logic [7:0]  pc;
  logic        running, halted;
  logic [15:0] inst_count;

  logic        start2, halt2;
  logic [1:0]  pc2;
  logic        running2, halted2;
  logic [15:0] count2;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem8 [256];
  logic [15:0] mem2 [4];
  int          dly   [64];
  int          hmode [64];   // 0 none, 1 halt_req on first ISSUE cycle, 2 with done

  fetch_unit_if #(.ADDR_W(8)) bus8 ();
  fetch_unit_if #(.ADDR_W(2)) bus2 ();

  fetch_unit #(.ADDR_W(8), .HALT_INST(C_HALT)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .bus(bus8.master),
    .pc(pc), .running(running), .halted(halted), .inst_count(inst_count)
  );

  fetch_unit #(.ADDR_W(2), .HALT_INST(C_HALT)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .halt_req(halt2), .bus(bus2.master),
    .pc(pc2), .running(running2), .halted(halted2), .inst_count(count2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus8.mem_rd) bus8.mem_data <= mem8[bus8.mem_addr];
  always @(posedge clk) if (bus2.mem_rd) bus2.mem_data <= mem2[bus2.mem_addr];

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] w0, w1, w2, w3;
    int          d;
    int          hidx;
    int          hm;
    logic [7:0]  epc;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl [5];

  function automatic vec_t mk(input logic [15:0] a, b, c, e, input int d, hidx, hm,
                              input logic [7:0] epc, input logic [15:0] ecnt);
    vec_t v;
    v.w0 = a; v.w1 = b; v.w2 = c; v.w3 = e;
    v.d = d; v.hidx = hidx; v.hm = hm; v.epc = epc; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},      {24'd0, pc}, 32'd0);
    chk({tag, "_count"},   {16'd0, inst_count}, 32'd0);
    chk({tag, "_inst"},    {16'd0, bus8.inst}, 32'd0);
    chk({tag, "_valid"},   {31'd0, bus8.inst_valid}, 32'd0);
    chk({tag, "_mem_rd"},  {31'd0, bus8.mem_rd}, 32'd0);
    chk({tag, "_running"}, {31'd0, running}, 32'd0);
    chk({tag, "_halted"},  {31'd0, halted}, 32'd0);
  endtask

  // Program-level model: fetch sequentially from 0, stop at a HALT word or after a halted instruction.
  function automatic void predict(output logic [7:0] epc, output logic [15:0] ecnt);
    int  a = 0;
    bit  stop = 0;
    while (!stop && a < 60) begin
      if (mem8[a] == C_HALT) stop = 1;
      else begin
        a++;
        if (hmode[a-1] != 0) stop = 1;
      end
    end
    epc  = a[7:0];
    ecnt = a[15:0];
  endfunction

  // Starts the program and acts as control unit; called with inputs idle just after a negedge.
  task automatic run_prog(input bit noise);
    int i = 0;
    bit fin = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!fin && i < 60) begin
      chk("fetch_rd",   {31'd0, bus8.mem_rd}, 32'd1);
      chk("fetch_addr", {24'd0, bus8.mem_addr}, i);
      bus8.done = noise;
      @(negedge clk);
      chk("wait_rd",    {31'd0, bus8.mem_rd}, 32'd0);
      chk("wait_valid", {31'd0, bus8.inst_valid}, 32'd0);
      @(negedge clk);
      bus8.done = 1'b0;
      if (mem8[i] == C_HALT) begin
        chk("halt_word_halted", {31'd0, halted}, 32'd1);
        chk("halt_word_valid",  {31'd0, bus8.inst_valid}, 32'd0);
        chk("halt_word_pc",     {24'd0, pc}, i);
        fin = 1;
      end else begin
        for (int c = 0; c <= dly[i]; c++) begin
          chk("issue_valid", {31'd0, bus8.inst_valid}, 32'd1);
          chk("issue_inst",  {16'd0, bus8.inst}, {16'd0, mem8[i]});
          halt_req  = (hmode[i] == 1 && c == 0) || (hmode[i] == 2 && c == dly[i]);
          start     = noise && (c == 0) && (dly[i] > 0);
          bus8.done = (c == dly[i]);
          @(negedge clk);
          halt_req = 1'b0; start = 1'b0; bus8.done = 1'b0;
        end
        chk("done_count", {16'd0, inst_count}, i + 1);
        chk("done_pc",    {24'd0, pc}, i + 1);
        if (hmode[i] != 0) begin
          chk("stop_halted", {31'd0, halted}, 32'd1);
          chk("stop_rd",     {31'd0, bus8.mem_rd}, 32'd0);
          fin = 1;
        end
        i++;
      end
    end
    chk("prog_finished", {31'd0, fin}, 32'd1);
  endtask

  task automatic clear_ctl();
    for (int j = 0; j < 64; j++) begin dly[j] = 0; hmode[j] = 0; end
  endtask

  initial begin
    logic [7:0]  epc;
    logic [15:0] ecnt;

    reset = 1'b1; start = 1'b0; halt_req = 1'b0; bus8.done = 1'b0;
    start2 = 1'b0; halt2 = 1'b0; bus2.done = 1'b0;
    for (int j = 0; j < 256; j++) mem8[j] = C_HALT;
    clear_ctl();
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // done in IDLE is ignored and IDLE persists without start
    bus8.done = 1'b1;
    @(negedge clk);
    bus8.done = 1'b0;
    @(negedge clk);
    chk("idle_done_running", {31'd0, running}, 32'd0);
    chk("idle_done_pc",      {24'd0, pc}, 32'd0);
    chk("idle_done_count",   {16'd0, inst_count}, 32'd0);

    tbl[0] = mk(16'h1234, 16'h5678, C_HALT,   16'h0000, 4, -1, 0, 8'd2, 16'd2);
    tbl[1] = mk(C_HALT,   16'h1111, 16'h2222, 16'h3333, 0, -1, 0, 8'd0, 16'd0);
    tbl[2] = mk(16'h0001, 16'h0002, 16'h0003, 16'h0004, 1,  2, 1, 8'd3, 16'd3);
    tbl[3] = mk(16'hAAAA, 16'h5555, 16'h0000, 16'h1111, 0,  0, 2, 8'd1, 16'd1);
    tbl[4] = mk(16'h0000, 16'h0001, 16'h0002, 16'h0003, 2, -1, 0, 8'd4, 16'd4);
    for (int t = 0; t < 5; t++) begin
      for (int j = 0; j < 256; j++) mem8[j] = C_HALT;
      mem8[0] = tbl[t].w0; mem8[1] = tbl[t].w1; mem8[2] = tbl[t].w2; mem8[3] = tbl[t].w3;
      clear_ctl();
      for (int j = 0; j < 8; j++) dly[j] = tbl[t].d;
      if (tbl[t].hidx >= 0) hmode[tbl[t].hidx] = tbl[t].hm;
      run_prog(1'b0);
      @(negedge clk);
      chk("tbl_halted", {31'd0, halted}, 32'd1);
      chk("tbl_pc",     {24'd0, pc}, {24'd0, tbl[t].epc});
      chk("tbl_count",  {16'd0, inst_count}, {16'd0, tbl[t].ecnt});
    end

    // halt_req during WAIT of address 0
    for (int j = 0; j < 256; j++) mem8[j] = 16'h1000 + j[15:0];
    start = 1'b1;    @(negedge clk);
    start = 1'b0;    @(negedge clk);
    halt_req = 1'b1; @(negedge clk);
    halt_req = 1'b0;
    chk("hw_valid", {31'd0, bus8.inst_valid}, 32'd1);
    chk("hw_inst",  {16'd0, bus8.inst}, 32'h1000);
    bus8.done = 1'b1; @(negedge clk);
    bus8.done = 1'b0;
    chk("hw_halted", {31'd0, halted}, 32'd1);
    chk("hw_pc",     {24'd0, pc}, 32'd1);
    chk("hw_count",  {16'd0, inst_count}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("hw_no_rd", {31'd0, bus8.mem_rd}, 32'd0);
    end

    // asynchronous reset in the middle of the second instruction
    start = 1'b1; @(negedge clk);
    start = 1'b0; @(negedge clk); @(negedge clk);
    bus8.done = 1'b1; @(negedge clk);
    bus8.done = 1'b0; @(negedge clk); @(negedge clk);
    chk("ar_valid_before", {31'd0, bus8.inst_valid}, 32'd1);
    chk("ar_pc_before",    {24'd0, pc}, 32'd1);
    #1 reset = 1'b1;
    #1 chk_reset_vals("async");
    repeat (3) begin
      @(negedge clk);
      bus8.done = 1'b1; start = 1'b1;
    end
    @(negedge clk);
    bus8.done = 1'b0; start = 1'b0;
    chk_reset_vals("held");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", {31'd0, running}, 32'd0);
    for (int j = 0; j < 256; j++) mem8[j] = C_HALT;
    mem8[0] = 16'h0ABC; mem8[1] = 16'h0DEF;
    clear_ctl();
    run_prog(1'b0);
    chk("restart_pc", {24'd0, pc}, 32'd2);

    // two-bit address space wraps after four instructions
    mem2[0] = 16'hA000; mem2[1] = 16'hA001; mem2[2] = 16'hA002; mem2[3] = 16'hA003;
    start2 = 1'b1; @(negedge clk);
    start2 = 1'b0;
    for (int j = 0; j < 5; j++) begin
      chk("w2_rd",   {31'd0, bus2.mem_rd}, 32'd1);
      chk("w2_addr", {30'd0, bus2.mem_addr}, j % 4);
      @(negedge clk); @(negedge clk);
      chk("w2_inst", {16'd0, bus2.inst}, {16'd0, mem2[j % 4]});
      halt2 = (j == 4);
      bus2.done = 1'b1; @(negedge clk);
      bus2.done = 1'b0; halt2 = 1'b0;
    end
    chk("w2_pc",     {30'd0, pc2}, 32'd1);
    chk("w2_count",  {16'd0, count2}, 32'd5);
    chk("w2_halted", {31'd0, halted2}, 32'd1);

    // random programs with spurious done/start noise
    for (int p = 0; p < 20; p++) begin
      for (int j = 0; j < 256; j++)
        mem8[j] = ($urandom_range(0, 7) == 0) ? C_HALT : 16'($urandom_range(0, 16'hFFFE));
      clear_ctl();
      for (int j = 0; j < 12; j++) begin
        dly[j] = $urandom_range(0, 3);
        if ($urandom_range(0, 5) == 0) hmode[j] = $urandom_range(1, 2);
      end
      hmode[11] = 2;
      predict(epc, ecnt);
      run_prog(1'b1);
      @(negedge clk);
      chk("rnd_halted", {31'd0, halted}, 32'd1);
      chk("rnd_pc",     {24'd0, pc}, {24'd0, epc});
      chk("rnd_count",  {16'd0, inst_count}, {16'd0, ecnt});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory address width.
REQ-002 Parameter HALT_INST, default 16'hFFFF, instruction encoding that stops fetching.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin execution from address 0; sampled only in IDLE or HALTED.
REQ-006 halt_req  input  1  request stop after the current instruction completes.
REQ-007 mem_rd  output  1  instruction-memory read strobe.
REQ-008 mem_addr  output  ADDR_W  read address; equals pc.
REQ-009 mem_data  input  16  read data, valid the cycle after mem_rd.
REQ-010 inst  output  16  held instruction word to the control unit.
REQ-011 inst_valid  output  1  inst is stable and being executed.
REQ-012 done  input  1  control unit end-of-instruction strobe.
REQ-013 pc  output  ADDR_W  address of the current/next instruction.
REQ-014 running  output  1  high in FETCH, WAIT, ISSUE.
REQ-015 halted  output  1  high in HALTED.
REQ-016 inst_count  output  16  instructions completed since last start.

Function
REQ-017 FSM states: IDLE, FETCH, WAIT, ISSUE, HALTED; registered outputs only.
REQ-018 IDLE: start=1 -> FETCH with pc=0, inst_count=0, halt pending cleared.
REQ-019 FETCH: one cycle, mem_rd=1, mem_addr=pc -> WAIT.
REQ-020 WAIT: one cycle, mem_rd=0; at edge ending WAIT, inst<=mem_data.
REQ-021 WAIT: mem_data==HALT_INST -> HALTED, inst_valid stays 0, inst_count and pc unchanged.
REQ-022 WAIT otherwise -> ISSUE.
REQ-023 ISSUE: inst_valid=1, inst held constant, stays until done=1 sampled.
REQ-024 ISSUE with done=1: pc<=pc+1 (modulo 2^ADDR_W, wraps to 0), inst_count<=inst_count+1 saturating at 16'hFFFF, inst_valid<=0.
REQ-025 ISSUE with done=1: halt pending -> HALTED; else -> FETCH.
REQ-026 halt_req=1 in any running state sets a sticky halt-pending flag; it never aborts an issued instruction.
REQ-027 halt_req=1 in FETCH or WAIT: that fetched instruction is still issued; stop after its done.
REQ-028 halt_req and done high in the same ISSUE cycle: the instruction counts and the FSM goes to HALTED.
REQ-029 done outside ISSUE is ignored; start while running is ignored.
REQ-030 HALTED: pc, inst, inst_count hold; start=1 -> FETCH as in REQ-018.
REQ-031 Latency: start sampled at edge k -> mem_rd high in cycle k+1, inst_valid high from cycle k+3.
REQ-032 Issue-to-issue: done sampled at edge m -> next inst_valid high from cycle m+3.

Reset
REQ-033 reset=1 forces immediately, regardless of clk: state IDLE, pc=0, inst=0, inst_valid=0, mem_rd=0, inst_count=0, running=0, halted=0, halt pending=0.
REQ-034 reset asserted mid-instruction abandons it: no count increment, no pc increment.
REQ-035 After reset deasserts, the FSM stays in IDLE until start.

Verification
REQ-036 Memory {0:16'h1234, 1:16'h5678, 2:HALT_INST}, start, done 4 cycles after each inst_valid rise -> inst 1234 then 5678, halted=1, pc=2, inst_count=2.
REQ-037 start at edge k -> mem_rd in cycle k+1 with mem_addr=0, inst_valid rises in cycle k+3; done at edge m -> mem_rd in cycle m+1.
REQ-038 halt_req pulsed during WAIT of address 0 -> instruction at 0 issued, after done halted=1, pc=1, inst_count=1, no further mem_rd.
REQ-039 ADDR_W=2, no HALT_INST in memory, 5 completed instructions -> mem_addr sequence 0,1,2,3,0; pc=1 after fifth done.
REQ-040 reset asserted asynchronously in ISSUE (between edges) -> outputs at REQ-033 values before next edge; done pulses and start ignored until reset released, then start restarts from 0.
REQ-041 Spurious done in IDLE, FETCH, WAIT and second start during ISSUE -> no pc, count or state change.
